bcd_display_scan: RTL and testbench

BCD_DISPLAY_SCAN -- requirements
Module: bcd_display_scan

---
 rtl/bcd_display_scan.sv | 105 ++++++++++
 tb/tb_bcd_display_scan.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed 7-segment scanner for cascaded BCD counters.
// A prescaler paces the digit slots. A frame snapshot is taken on each
// index wrap so a frame never mixes old and new digits. A sticky overflow
// flag is shown on the decimal point of the most significant digit.

// Decodes one BCD digit to segments {a,b,c,d,e,f,g}. Blanking overrides the decode.
module bcd_display_scan_dec (
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);
  // Digits 0-9 map to their glyphs, A-F show a dash, and blanking forces all segments off
  always_comb begin
    seg = 7'b0000001;
    case (bcd)
      4'd0: seg = 7'b1111110;
      4'd1: seg = 7'b0110000;
      4'd2: seg = 7'b1101101;
      4'd3: seg = 7'b1111001;
      4'd4: seg = 7'b0110011;
      4'd5: seg = 7'b1011011;
      4'd6: seg = 7'b1011111;
      4'd7: seg = 7'b1110000;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1111011;
      default: seg = 7'b0000001;
    endcase
    if (blank) seg = 7'b0000000;
  end
endmodule

module bcd_display_scan #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic        carry_in,
  input  logic        clr_ovf,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        ovf
);
  localparam int unsigned   PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  logic [PW-1:0]   pre_q, pre_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     snap_q, snap_d;
  logic            ovf_q, ovf_d;
  logic            tick;
  logic [3:0][6:0] lane_seg;

  // Prescaler, scan index, frame snapshot and sticky overflow next-state
  always_comb begin
    tick   = (pre_q == PRE_LAST);
    pre_d  = tick ? '0 : pre_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    // Load only as the index wraps to 0, so a frame is always consistent
    snap_d = (tick && (idx_q == 2'd3)) ? digits : snap_q;
    ovf_d  = ovf_q;
    if (carry_in)     ovf_d = 1'b1;   // a new carry beats a simultaneous clear
    else if (clr_ovf) ovf_d = 1'b0;
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      idx_q  <= 2'd0;
      snap_q <= 16'h0000;
      ovf_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      ovf_q  <= ovf_d;
    end
  end

  // One decoder per digit. Digit k blanks when it and all higher digits are zero.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic lane_blank;
    if (k == 0) begin : g_d0
      assign lane_blank = 1'b0;
    end else begin : g_dk
      assign lane_blank = blank_lz && ((snap_q >> (4 * k)) == 16'd0);
    end
    bcd_display_scan_dec u_dec (
      .bcd   (snap_q[4*k +: 4]),
      .blank (lane_blank),
      .seg   (lane_seg[k])
    );
  end

  // Outputs depend only on registered state plus blank_lz
  always_comb begin
    an  = 4'b0001 << idx_q;
    seg = lane_seg[idx_q];
    dp  = (idx_q == 2'd3) && ovf_q;
    ovf = ovf_q;
  end
endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench for bcd_display_scan with SCAN_DIV=4.
// Stimulus pushes cycle-tagged expected outputs into a queue.
// A negedge monitor pops and compares each entry when its cycle arrives.
module tb_bcd_display_scan;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic        carry_in, clr_ovf, blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        ovf;

  bcd_display_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .digits(digits), .carry_in(carry_in),
    .clr_ovf(clr_ovf), .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ovf;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   failures = 0;

  localparam logic [6:0] Z  = 7'b1111110;
  localparam logic [6:0] D1 = 7'b0110000;
  localparam logic [6:0] D2 = 7'b1101101;
  localparam logic [6:0] D3 = 7'b1111001;
  localparam logic [6:0] D4 = 7'b0110011;
  localparam logic [6:0] D9 = 7'b1111011;
  localparam logic [6:0] DA = 7'b0000001;
  localparam logic [6:0] BL = 7'b0000000;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every due scoreboard entry against the live outputs
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      m = sb.pop_front();
      checks++;
      if (m.cyc != cyc || an !== m.an || seg !== m.seg || dp !== m.dp || ovf !== m.ovf) begin
        failures++;
        $display("FAIL %s cyc=%0d/%0d an=%b exp %b seg=%b exp %b dp=%b exp %b ovf=%b exp %b",
                 m.nm, cyc, m.cyc, an, m.an, seg, m.seg, dp, m.dp, ovf, m.ovf);
      end
    end
  end

  task automatic push_one(input string nm, input int c, input logic [3:0] a,
                          input logic [6:0] s, input logic d, input logic o);
    exp_t e;
    e.cyc = c; e.an = a; e.seg = s; e.dp = d; e.ovf = o; e.nm = nm;
    sb.push_back(e);
  endtask

  // Expected outputs for cycles j_lo..j_hi of frame f (16 cycles, 4 per slot)
  task automatic push_frame(input string nm, input int f, input logic [6:0] s0,
                            input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                            input logic ov, input int j_lo, input int j_hi);
    for (int j = j_lo; j <= j_hi; j++) begin
      int sl;
      logic [6:0] s;
      sl = j / 4;
      s  = (sl == 0) ? s0 : (sl == 1) ? s1 : (sl == 2) ? s2 : s3;
      push_one(nm, base + 16*f + j, 4'b0001 << sl, s, (sl == 3) && ov, ov);
    end
  endtask

  // Advance to 1 time unit after the posedge that makes cyc == base+k
  task automatic wait_k(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int n;
    reset = 1'b0; digits = 16'h0; carry_in = 1'b0; clr_ovf = 1'b0; blank_lz = 1'b0;
    for (int c = 1; c <= 5; c++) push_one("reset", c, 4'b0001, Z, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      digits   = 16'($urandom);
      carry_in = 1'($urandom);
      clr_ovf  = 1'($urandom);
      blank_lz = 1'($urandom);
    end
    digits = 16'h1234; carry_in = 1'b0; clr_ovf = 1'b0; blank_lz = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    base  = cyc;

    push_frame("frame0", 0, Z, Z, Z, Z, 1'b0, 1, 15);
    push_frame("scan", 1, D4, D3, D2, D1, 1'b0, 0, 15);
    push_frame("scan", 2, D4, D3, D2, D1, 1'b0, 0, 15);

    wait_k(40);
    digits = 16'h0042;
    push_frame("blank_on", 3, D2, D4, BL, BL, 1'b0, 0, 15);
    wait_k(48);
    blank_lz = 1'b1;

    wait_k(64);
    blank_lz = 1'b0;
    digits   = 16'h1111;
    push_frame("blank_off", 4, D2, D4, Z, Z, 1'b0, 0, 15);
    push_frame("midframe_old", 5, D1, D1, D1, D1, 1'b0, 0, 15);
    wait_k(84);
    digits = 16'h9999;
    push_frame("midframe_new", 6, D9, D9, D9, D9, 1'b0, 0, 15);

    wait_k(111);
    carry_in = 1'b1;
    push_frame("ovf_set", 7, D9, D9, D9, D9, 1'b1, 0, 15);
    wait_k(112);
    carry_in = 1'b0;

    wait_k(127);
    carry_in = 1'b1; clr_ovf = 1'b1;
    push_frame("ovf_both", 8, D9, D9, D9, D9, 1'b1, 0, 15);
    wait_k(128);
    carry_in = 1'b0; clr_ovf = 1'b0;

    wait_k(143);
    clr_ovf = 1'b1;
    push_frame("ovf_clr", 9, D9, D9, D9, D9, 1'b0, 0, 15);
    wait_k(144);
    clr_ovf = 1'b0;
    digits  = 16'h000B;

    wait_k(159);
    carry_in = 1'b1;
    push_frame("invalid", 10, DA, Z, Z, Z, 1'b1, 0, 15);
    push_frame("invalid", 11, DA, Z, Z, Z, 1'b1, 0, 8);
    wait_k(160);
    carry_in = 1'b0;

    wait_k(185);
    for (int k = 185; k <= 187; k++) push_one("mid_reset", base + k, 4'b0001, Z, 1'b0, 1'b0);
    reset = 1'b0;
    wait_k(187);
    for (int k = 188; k <= 190; k++) push_one("restart", base + k, 4'b0001, Z, 1'b0, 1'b0);
    reset = 1'b1;

    n = 0;
    while (sb.size() > 0 && n < 64) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      $display("FAIL drain pending=%0d required 0", sb.size());
      checks   += sb.size();
      failures += sb.size();
    end
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
